// File: rtl/vector_bitwise_pkg.sv
// Shared types and constants for the vector bitwise element sequencer.
// The optional write mask is enabled with the VBW_SEQ_MASK_EN macro.
package vector_bitwise_pkg;

    localparam int VBW_DATA_W = 32;

    localparam logic [1:0] VBW_AND = 2'b00;
    localparam logic [1:0] VBW_OR  = 2'b01;
    localparam logic [1:0] VBW_XOR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vbw_state_t;

endpackage

// File: rtl/vector_bitwise_elem_pipe.sv
// S1..S3 element pipeline: operand capture, bitwise-unit result capture, write.
// Honours a per-element write mask that the top ties high when VBW_SEQ_MASK_EN is off.
module vector_bitwise_elem_pipe
    import vector_bitwise_pkg::*;
#(
    parameter int MAX_VL = 16,
    parameter int IDX_W  = $clog2(MAX_VL)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_elem,
    input  logic [VBW_DATA_W-1:0] rd_data_a,
    input  logic [VBW_DATA_W-1:0] rd_data_b,
    input  logic [MAX_VL-1:0]     mask,
    output logic [VBW_DATA_W-1:0] op_a,
    output logic [VBW_DATA_W-1:0] op_b,
    input  logic [VBW_DATA_W-1:0] bou_result,
    output logic                  wr_en,
    output logic [IDX_W-1:0]      wr_elem,
    output logic [VBW_DATA_W-1:0] wr_data,
    output logic                  empty
);

    logic                  s1_valid;
    logic [IDX_W-1:0]      s1_idx;
    logic                  s2_valid;
    logic [IDX_W-1:0]      s2_idx;
    logic                  s3_valid;
    logic [IDX_W-1:0]      s3_idx;
    logic [VBW_DATA_W-1:0] s3_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            s3_valid <= 1'b0;
            s3_idx   <= '0;
            s3_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            s1_idx   <= rd_elem;
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            // Read data is only meaningful in the cycle after the request.
            if (s1_valid) begin
                op_a <= rd_data_a;
                op_b <= rd_data_b;
            end
            s3_valid <= s2_valid;
            s3_idx   <= s2_idx;
            if (s2_valid) begin
                s3_data <= bou_result;
            end
        end
    end

    assign wr_en   = s3_valid && mask[s3_idx];
    assign wr_elem = s3_idx;
    assign wr_data = s3_data;

    // S3 retires this cycle, so the pipe is empty after the edge when S1/S2 are clear.
    assign empty = !s1_valid && !s2_valid;

endmodule

// File: rtl/vector_bitwise_sequencer.sv
// Element sequencer for vector AND/OR/XOR: issues one element read per cycle and
// writes results through a 3-stage pipe. Optional write mask: VBW_SEQ_MASK_EN.
module vector_bitwise_sequencer
    import vector_bitwise_pkg::*;
#(
    parameter int MAX_VL = 16,
    parameter int VREG_W = 5,
    parameter int IDX_W  = $clog2(MAX_VL)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [1:0]            instr_op,
    input  logic [VREG_W-1:0]     instr_vs1,
    input  logic [VREG_W-1:0]     instr_vs2,
    input  logic [VREG_W-1:0]     instr_vd,
    input  logic [IDX_W:0]        instr_vl,
`ifdef VBW_SEQ_MASK_EN
    input  logic [MAX_VL-1:0]     mask_in,
`endif
    output logic                  rd_en,
    output logic [VREG_W-1:0]     rd_vreg_a,
    output logic [VREG_W-1:0]     rd_vreg_b,
    output logic [IDX_W-1:0]      rd_elem,
    input  logic [VBW_DATA_W-1:0] rd_data_a,
    input  logic [VBW_DATA_W-1:0] rd_data_b,
    output logic [VBW_DATA_W-1:0] bou_operand_a,
    output logic [VBW_DATA_W-1:0] bou_operand_b,
    output logic [1:0]            bou_control,
    input  logic [VBW_DATA_W-1:0] bou_result,
    output logic                  wr_en,
    output logic [VREG_W-1:0]     wr_vreg,
    output logic [IDX_W-1:0]      wr_elem,
    output logic [VBW_DATA_W-1:0] wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [IDX_W:0] VL_MAX = (IDX_W+1)'(MAX_VL);

    vbw_state_t        state;
    vbw_state_t        state_nxt;
    logic [1:0]        op_q;
    logic [VREG_W-1:0] vs1_q;
    logic [VREG_W-1:0] vs2_q;
    logic [VREG_W-1:0] vd_q;
    logic [IDX_W:0]    vl_q;
    logic [IDX_W:0]    vl_clamp;
    logic [IDX_W-1:0]  cnt;
    logic [MAX_VL-1:0] mask_q;
    logic              accept;
    logic              last_elem;
    logic              pipe_empty;

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready depends only on the FSM being IDLE.
    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid && instr_ready;
    assign vl_clamp    = (instr_vl > VL_MAX) ? VL_MAX : instr_vl;
    assign last_elem   = ({1'b0, cnt} == vl_q - 1'b1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (vl_clamp == '0) ? DONE : ISSUE;
            ISSUE:   if (last_elem) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
            vs1_q <= '0;
            vs2_q <= '0;
            vd_q  <= '0;
            vl_q  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= instr_op;
                vs1_q <= instr_vs1;
                vs2_q <= instr_vs2;
                vd_q  <= instr_vd;
                vl_q  <= vl_clamp;
                cnt   <= '0;
            end else if (state == ISSUE) begin
                cnt <= last_elem ? '0 : cnt + 1'b1;
            end
        end
    end

`ifdef VBW_SEQ_MASK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= mask_in;
        end
    end
`else
    assign mask_q = '1;
`endif

    assign rd_en       = (state == ISSUE);
    assign rd_vreg_a   = vs1_q;
    assign rd_vreg_b   = vs2_q;
    assign rd_elem     = cnt;
    // The reserved op is forwarded untouched; the unit itself yields zero for it.
    assign bou_control = op_q;
    assign wr_vreg     = vd_q;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    vector_bitwise_elem_pipe #(
        .MAX_VL(MAX_VL),
        .IDX_W (IDX_W)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .rd_elem   (cnt),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .mask      (mask_q),
        .op_a      (bou_operand_a),
        .op_b      (bou_operand_b),
        .bou_result(bou_result),
        .wr_en     (wr_en),
        .wr_elem   (wr_elem),
        .wr_data   (wr_data),
        .empty     (pipe_empty)
    );

endmodule

// File: tb/tb_vector_bitwise_sequencer.sv
// Directed bench for vector_bitwise_sequencer with a register-file and bitwise-unit model.
// The mask case is built only when VBW_SEQ_MASK_EN is defined.
`timescale 1ns/1ps
module tb_vector_bitwise_sequencer;

    localparam int MAX_VL = 16;
    localparam int VREG_W = 5;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [1:0]        instr_op = '0;
    logic [VREG_W-1:0] instr_vs1 = '0;
    logic [VREG_W-1:0] instr_vs2 = '0;
    logic [VREG_W-1:0] instr_vd = '0;
    logic [IDX_W:0]    instr_vl = '0;
    logic [MAX_VL-1:0] mask_in = '1;
    logic              rd_en;
    logic [VREG_W-1:0] rd_vreg_a;
    logic [VREG_W-1:0] rd_vreg_b;
    logic [IDX_W-1:0]  rd_elem;
    logic [31:0]       rd_data_a = '0;
    logic [31:0]       rd_data_b = '0;
    logic [31:0]       bou_operand_a;
    logic [31:0]       bou_operand_b;
    logic [1:0]        bou_control;
    logic [31:0]       bou_result;
    logic              wr_en;
    logic [VREG_W-1:0] wr_vreg;
    logic [IDX_W-1:0]  wr_elem;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;

    vector_bitwise_sequencer #(.MAX_VL(MAX_VL), .VREG_W(VREG_W), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_vs1    (instr_vs1),
        .instr_vs2    (instr_vs2),
        .instr_vd     (instr_vd),
        .instr_vl     (instr_vl),
`ifdef VBW_SEQ_MASK_EN
        .mask_in      (mask_in),
`endif
        .rd_en        (rd_en),
        .rd_vreg_a    (rd_vreg_a),
        .rd_vreg_b    (rd_vreg_b),
        .rd_elem      (rd_elem),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .bou_operand_a(bou_operand_a),
        .bou_operand_b(bou_operand_b),
        .bou_control  (bou_control),
        .bou_result   (bou_result),
        .wr_en        (wr_en),
        .wr_vreg      (wr_vreg),
        .wr_elem      (wr_elem),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int ecnt = 0;
    int acc_edge = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    // ---------------- environment models ----------------
    logic [31:0] vrf [0:31][0:MAX_VL-1];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= vrf[rd_vreg_a][rd_elem];
            rd_data_b <= vrf[rd_vreg_b][rd_elem];
        end else begin
            rd_data_a <= 32'h0;
            rd_data_b <= 32'h0;
        end
    end

    always_comb begin
        bou_result = 32'h0;
        case (bou_control)
            2'b00:   bou_result = bou_operand_a & bou_operand_b;
            2'b01:   bou_result = bou_operand_a | bou_operand_b;
            2'b10:   bou_result = bou_operand_a ^ bou_operand_b;
            default: bou_result = 32'h0;
        endcase
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    int          exp_elem_q[$];
    int          exp_vreg_q[$];
    int          exp_cyc_q[$];

    int rd_count, rd_first, rd_last, done_count, done_cyc, ready_cyc, mon_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int elem, input logic [31:0] data, input int vd, input int cyc);
        exp_q.push_back(data);
        exp_elem_q.push_back(elem);
        exp_vreg_q.push_back(vd);
        exp_cyc_q.push_back(cyc);
    endtask

    // Sample 1ns after the falling edge; cycle 1 is the one following the acceptance edge.
    always begin
        @(negedge clk);
        #1;
        mon_cyc = ecnt - acc_edge + 1;
        if (rd_en) begin
            rd_count++;
            if (rd_first < 0) rd_first = mon_cyc;
            rd_last = mon_cyc;
        end
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {31'b0, wr_en}, 32'd0);
            end else begin
                check("wr_data", wr_data, exp_q.pop_front());
                check("wr_elem", 32'(wr_elem), exp_elem_q.pop_front());
                check("wr_vreg", 32'(wr_vreg), exp_vreg_q.pop_front());
                check("wr_cycle", mon_cyc, exp_cyc_q.pop_front());
            end
        end
        if (done) begin
            done_count++;
            done_cyc = mon_cyc;
        end
        if (instr_ready && ready_cyc < 0 && mon_cyc >= 1) ready_cyc = mon_cyc;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int target);
        while (ecnt - acc_edge + 1 < target) @(negedge clk);
        #2;
    endtask

    // Caller sits just after a falling edge; returns at cycle 0 (hold) or cycle 1.
    task automatic issue(input logic [1:0] op, input int vs1, input int vs2, input int vd,
                         input int vl, input logic [MAX_VL-1:0] mask, input bit hold);
        int guard = 0;
        instr_op    = op;
        instr_vs1   = VREG_W'(vs1);
        instr_vs2   = VREG_W'(vs2);
        instr_vd    = VREG_W'(vd);
        instr_vl    = (IDX_W+1)'(vl);
        mask_in     = mask;
        instr_valid = 1'b1;
        while (!instr_ready && guard < 200) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (!instr_ready) begin
            check("ready_timeout", {31'b0, instr_ready}, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        acc_edge   = ecnt + 1;
        rd_count   = 0;
        rd_first   = -1;
        rd_last    = -1;
        done_count = 0;
        done_cyc   = -1;
        ready_cyc  = -1;
        if (!hold) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
    endtask

    task automatic finish_instr(input string tag, input int vl_eff, input int exp_done,
                                input int exp_ready);
        wait_cyc(exp_ready + 2);
        check({tag, "_done_count"}, done_count, 1);
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_ready_cyc"}, ready_cyc, exp_ready);
        check({tag, "_rd_count"}, rd_count, vl_eff);
        if (vl_eff > 0) begin
            check({tag, "_rd_first"}, rd_first, 1);
            check({tag, "_rd_last"}, rd_last, vl_eff);
        end
        check({tag, "_wr_missing"}, exp_q.size(), 0);
        exp_q.delete();
        exp_elem_q.delete();
        exp_vreg_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, {31'b0, instr_ready}, 32'd1);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_rd_en"}, {31'b0, rd_en}, 32'd0);
        check({tag, "_wr_en"}, {31'b0, wr_en}, 32'd0);
        check({tag, "_addrs"}, 32'({rd_vreg_a, rd_vreg_b, rd_elem, wr_vreg, wr_elem}), 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
        check({tag, "_bou_a"}, bou_operand_a, 32'd0);
        check({tag, "_bou_b"}, bou_operand_b, 32'd0);
        check({tag, "_bou_ctl"}, 32'(bou_control), 32'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        for (int r = 0; r < 32; r++)
            for (int e = 0; e < MAX_VL; e++) vrf[r][e] = 32'h0;
        for (int e = 0; e < MAX_VL; e++) begin
            vrf[1][e] = 32'hFFFF0000;
            vrf[2][e] = 32'h0F0F0F0F;
            vrf[3][e] = 32'h10203040 + e * 32'h01010101;
            vrf[7][e] = 32'h1 << e;
            vrf[8][e] = 32'h80000000;
        end
        vrf[5][0] = 32'h1;
        vrf[6][0] = 32'h2;
        rd_count = 0; rd_first = -1; rd_last = -1;
        done_count = 0; done_cyc = -1; ready_cyc = -1; mon_cyc = 0;

        // Outputs while reset is held
        @(negedge clk); #2;
        check_idle("reset");
        @(negedge clk); #2;
        reset = 1'b0;
        @(negedge clk); #2;

        // AND, vl=4: writes in cycles 4..7, done in 8
        for (int i = 0; i < 4; i++) push_exp(i, 32'h0F0F0000, 10, 4 + i);
        issue(2'b00, 1, 2, 10, 4, '1, 1'b0);
        finish_instr("and4", 4, 8, 9);

        // XOR, vl=MAX_VL, A=B: all zero
        for (int i = 0; i < 16; i++) push_exp(i, 32'h00000000, 11, 4 + i);
        issue(2'b10, 3, 3, 11, 16, '1, 1'b0);
        finish_instr("xor16", 16, 20, 21);

        // OR, vl=1: 0x1 | 0x2
        push_exp(0, 32'h00000003, 12, 4);
        issue(2'b01, 5, 6, 12, 1, '1, 1'b0);
        finish_instr("or1", 1, 5, 6);

        // vl=0: no traffic, done in cycle 1
        issue(2'b00, 1, 2, 13, 0, '1, 1'b0);
        finish_instr("vl0", 0, 1, 2);

        // vl=MAX_VL+1 clamps to MAX_VL
        for (int i = 0; i < 16; i++) push_exp(i, (32'h1 << i) | 32'h80000000, 14, 4 + i);
        issue(2'b01, 7, 8, 14, 17, '1, 1'b0);
        finish_instr("clamp", 16, 20, 21);

        // Reserved op writes zeros
        for (int i = 0; i < 2; i++) push_exp(i, 32'h00000000, 15, 4 + i);
        issue(2'b11, 1, 2, 15, 2, '1, 1'b0);
        finish_instr("op11", 2, 6, 7);

        // Reset in cycle 3 of a vl=8 instruction
        issue(2'b00, 1, 2, 9, 8, '1, 1'b0);
        wait_cyc(3);
        reset = 1'b1;
        @(negedge clk); #2;
        check_idle("rst_mid");
        @(negedge clk); #2;
        reset = 1'b0;
        repeat (15) @(negedge clk);
        #2;
        check("rst_mid_no_done", done_count, 0);
        check("rst_mid_ready_after", {31'b0, instr_ready}, 32'd1);
        check("rst_mid_no_wr", exp_q.size(), 0);

        // Back-to-back with instr_valid held: second accept in cycle vl+5
        for (int i = 0; i < 2; i++) push_exp(i, 32'h0F0F0000, 16, 4 + i);
        issue(2'b00, 1, 2, 16, 2, '1, 1'b1);
        wait_cyc(6);
        check("b2b_ready_low", {31'b0, instr_ready}, 32'd0);
        check("b2b_done_a", {31'b0, done}, 32'd1);
        wait_cyc(7);
        check("b2b_ready_high", {31'b0, instr_ready}, 32'd1);
        check("b2b_a_writes", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) push_exp(i, (32'h1 << i) ^ 32'h80000000, 17, 4 + i);
        issue(2'b10, 7, 8, 17, 3, '1, 1'b0);
        finish_instr("b2b_b", 3, 7, 8);

`ifdef VBW_SEQ_MASK_EN
        // Mask 0101: only elements 0 and 2 written, timing unchanged
        push_exp(0, 32'h0F0F0000, 18, 4);
        push_exp(2, 32'h0F0F0000, 18, 6);
        issue(2'b00, 1, 2, 18, 4, 16'h0005, 1'b0);
        finish_instr("mask", 4, 8, 9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
